// File: rtl/syn_sram_arb.sv
// Round-robin arbiter sharing one 16-bit asynchronous SRAM between NUM_AGENTS requesters.
// Each grant runs one 2-cycle SRAM access (sample in IDLE, strobe in RD/WR); all outputs registered.
module syn_sram_arb #(
    parameter int NUM_AGENTS = 3,
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 16
) (
    input  logic                           clk_ir,
    input  logic                           rst_il,
    input  logic [NUM_AGENTS-1:0]          agent_req_i,
    input  logic [NUM_AGENTS-1:0]          agent_we_i,
    input  logic [NUM_AGENTS*ADDR_W-1:0]   agent_addr_i,
    input  logic [NUM_AGENTS*DATA_W-1:0]   agent_wdata_i,
    input  logic [NUM_AGENTS*2-1:0]        agent_be_i,
    output logic [NUM_AGENTS-1:0]          agent_ack_o,
    output logic [NUM_AGENTS-1:0]          agent_rd_valid_o,
    output logic [DATA_W-1:0]              agent_rd_data_o,
    output logic [ADDR_W-1:0]              sram_addr_o,
    output logic [DATA_W-1:0]              sram_dq_o,
    output logic                           sram_dq_oe_o,
    input  logic [DATA_W-1:0]              sram_dq_i,
    output logic                           sram_ce_n_o,
    output logic                           sram_we_n_o,
    output logic                           sram_oe_n_o,
    output logic                           sram_lb_n_o,
    output logic                           sram_ub_n_o
);

    localparam int PTR_W = (NUM_AGENTS > 1) ? $clog2(NUM_AGENTS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [PTR_W-1:0]      r_ptr;
    logic [NUM_AGENTS-1:0] r_gnt;
    logic [NUM_AGENTS-1:0] r_ack;
    logic [NUM_AGENTS-1:0] r_rd_valid;
    logic [DATA_W-1:0]     r_rd_data;
    logic [ADDR_W-1:0]     r_sram_addr;
    logic [DATA_W-1:0]     r_dq;
    logic                  r_dq_oe;
    logic                  r_ce_n;
    logic                  r_we_n;
    logic                  r_oe_n;
    logic                  r_lb_n;
    logic                  r_ub_n;

    logic [PTR_W-1:0]      w_ptr_nxt;
    logic [NUM_AGENTS-1:0] w_gnt_nxt;
    logic [NUM_AGENTS-1:0] w_ack_nxt;
    logic [NUM_AGENTS-1:0] w_rd_valid_nxt;
    logic [DATA_W-1:0]     w_rd_data_nxt;
    logic [ADDR_W-1:0]     w_addr_nxt;
    logic [DATA_W-1:0]     w_dq_nxt;
    logic                  w_dq_oe_nxt;
    logic                  w_ce_n_nxt;
    logic                  w_we_n_nxt;
    logic                  w_oe_n_nxt;
    logic                  w_lb_n_nxt;
    logic                  w_ub_n_nxt;

    logic                  w_found;
    logic [PTR_W-1:0]      w_win;
    logic [NUM_AGENTS-1:0] w_win_oh;
    logic [ADDR_W-1:0]     w_sel_addr;
    logic [DATA_W-1:0]     w_sel_wdata;
    logic [1:0]            w_sel_be;
    logic                  w_sel_we;

    // Search upward from the pointer, wrapping, for the first requesting agent.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < NUM_AGENTS; i++) begin
            if (!w_found && agent_req_i[(int'(r_ptr) + i) % NUM_AGENTS]) begin
                w_found = 1'b1;
                w_win   = PTR_W'((int'(r_ptr) + i) % NUM_AGENTS);
            end
        end
    end

    assign w_win_oh    = NUM_AGENTS'(1) << w_win;
    assign w_sel_addr  = agent_addr_i[int'(w_win)*ADDR_W +: ADDR_W];
    assign w_sel_wdata = agent_wdata_i[int'(w_win)*DATA_W +: DATA_W];
    assign w_sel_be    = agent_be_i[int'(w_win)*2 +: 2];
    assign w_sel_we    = agent_we_i[w_win];

    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = S_IDLE;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = w_sel_we ? S_WR : S_RD;
                end
            end
            S_RD:    w_state_nxt = S_IDLE;
            S_WR:    w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Strobes default to inactive, so every access lasts exactly one strobe cycle.
    always_comb begin
        w_ptr_nxt      = r_ptr;
        w_gnt_nxt      = r_gnt;
        w_ack_nxt      = '0;
        w_rd_valid_nxt = '0;
        w_rd_data_nxt  = r_rd_data;
        w_addr_nxt     = r_sram_addr;
        w_dq_nxt       = r_dq;
        w_dq_oe_nxt    = 1'b0;
        w_ce_n_nxt     = 1'b1;
        w_we_n_nxt     = 1'b1;
        w_oe_n_nxt     = 1'b1;
        w_lb_n_nxt     = 1'b1;
        w_ub_n_nxt     = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_ptr_nxt  = (w_win == PTR_W'(NUM_AGENTS - 1)) ? '0 : w_win + 1'b1;
                    w_gnt_nxt  = w_win_oh;
                    w_ack_nxt  = w_win_oh;
                    w_addr_nxt = w_sel_addr;
                    w_ce_n_nxt = 1'b0;
                    w_lb_n_nxt = ~w_sel_be[0];
                    w_ub_n_nxt = ~w_sel_be[1];
                    if (w_sel_we) begin
                        w_we_n_nxt  = 1'b0;
                        w_dq_nxt    = w_sel_wdata;
                        w_dq_oe_nxt = 1'b1;
                    end else begin
                        w_oe_n_nxt  = 1'b0;
                    end
                end
            end
            S_RD: begin
                w_rd_data_nxt  = sram_dq_i;
                w_rd_valid_nxt = r_gnt;
            end
            S_WR: begin
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_ack       <= '0;
            r_rd_valid  <= '0;
            r_rd_data   <= '0;
            r_sram_addr <= '0;
            r_dq        <= '0;
            r_dq_oe     <= 1'b0;
            r_ce_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_lb_n      <= 1'b1;
            r_ub_n      <= 1'b1;
        end else begin
            r_ptr       <= w_ptr_nxt;
            r_gnt       <= w_gnt_nxt;
            r_ack       <= w_ack_nxt;
            r_rd_valid  <= w_rd_valid_nxt;
            r_rd_data   <= w_rd_data_nxt;
            r_sram_addr <= w_addr_nxt;
            r_dq        <= w_dq_nxt;
            r_dq_oe     <= w_dq_oe_nxt;
            r_ce_n      <= w_ce_n_nxt;
            r_we_n      <= w_we_n_nxt;
            r_oe_n      <= w_oe_n_nxt;
            r_lb_n      <= w_lb_n_nxt;
            r_ub_n      <= w_ub_n_nxt;
        end
    end

    assign agent_ack_o      = r_ack;
    assign agent_rd_valid_o = r_rd_valid;
    assign agent_rd_data_o  = r_rd_data;
    assign sram_addr_o      = r_sram_addr;
    assign sram_dq_o        = r_dq;
    assign sram_dq_oe_o     = r_dq_oe;
    assign sram_ce_n_o      = r_ce_n;
    assign sram_we_n_o      = r_we_n;
    assign sram_oe_n_o      = r_oe_n;
    assign sram_lb_n_o      = r_lb_n;
    assign sram_ub_n_o      = r_ub_n;

endmodule

// File: tb/tb_syn_sram_arb.sv
// Directed bench for syn_sram_arb with a small behavioural SRAM on the pad side.
module tb_syn_sram_arb;

    logic        clk = 1'b0;
    logic        rst_il;
    logic [2:0]  req;
    logic [2:0]  we;
    logic [53:0] addr;
    logic [47:0] wdata;
    logic [5:0]  be;
    logic [2:0]  ack;
    logic [2:0]  rd_valid;
    logic [15:0] rd_data;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_o;
    logic        dq_oe;
    logic [15:0] sram_dq_i;
    logic        ce_n, we_n, oe_n, lb_n, ub_n;

    logic [15:0] mem [0:255];

    int checks   = 0;
    int failures = 0;

    syn_sram_arb #(.NUM_AGENTS(3), .ADDR_W(18), .DATA_W(16)) dut (
        .clk_ir           (clk),
        .rst_il           (rst_il),
        .agent_req_i      (req),
        .agent_we_i       (we),
        .agent_addr_i     (addr),
        .agent_wdata_i    (wdata),
        .agent_be_i       (be),
        .agent_ack_o      (ack),
        .agent_rd_valid_o (rd_valid),
        .agent_rd_data_o  (rd_data),
        .sram_addr_o      (sram_addr),
        .sram_dq_o        (sram_dq_o),
        .sram_dq_oe_o     (dq_oe),
        .sram_dq_i        (sram_dq_i),
        .sram_ce_n_o      (ce_n),
        .sram_we_n_o      (we_n),
        .sram_oe_n_o      (oe_n),
        .sram_lb_n_o      (lb_n),
        .sram_ub_n_o      (ub_n)
    );

    always #5 clk = ~clk;

    // Asynchronous SRAM: reads while selected and output-enabled, writes lanes mid-cycle.
    assign sram_dq_i = (!ce_n && !oe_n) ? mem[sram_addr[7:0]] : 16'h0000;

    always @(negedge clk) begin
        if (!ce_n && !we_n) begin
            if (!lb_n) mem[sram_addr[7:0]][7:0]  <= sram_dq_o[7:0];
            if (!ub_n) mem[sram_addr[7:0]][15:8] <= sram_dq_o[15:8];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_agent(input int k, input logic w, input logic [17:0] a,
                             input logic [15:0] d, input logic [1:0] b);
        we[k]           = w;
        addr[k*18 +: 18] = a;
        wdata[k*16 +: 16] = d;
        be[k*2 +: 2]     = b;
    endtask

    function automatic logic [4:0] strobes();
        return {ce_n, we_n, oe_n, lb_n, ub_n};
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        rst_il = 1'b0;
        req    = '0;
        we     = '0;
        addr   = '0;
        wdata  = '0;
        be     = '0;

        // Reset state
        tick;
        tick;
        chk("rst_strobes",  32'(strobes()), 32'h1F);
        chk("rst_dq_oe",    32'(dq_oe),     32'h0);
        chk("rst_ack",      32'(ack),       32'h0);
        chk("rst_rd_valid", 32'(rd_valid),  32'h0);
        chk("rst_rd_data",  32'(rd_data),   32'h0);
        chk("rst_addr",     32'(sram_addr), 32'h0);
        chk("rst_dq",       32'(sram_dq_o), 32'h0);
        rst_il = 1'b1;
        tick;

        // Agent1 write 0xBEEF to 0x00123
        set_agent(1, 1'b1, 18'h00123, 16'hBEEF, 2'b11);
        req = 3'b010;
        tick;
        chk("wr_ack",     32'(ack),       32'h2);
        chk("wr_strobes", 32'(strobes()), 32'h04);
        chk("wr_addr",    32'(sram_addr), 32'h00123);
        chk("wr_dq",      32'(sram_dq_o), 32'hBEEF);
        chk("wr_dq_oe",   32'(dq_oe),     32'h1);
        req = 3'b000;
        tick;
        chk("wr_end_ack",     32'(ack),       32'h0);
        chk("wr_end_strobes", 32'(strobes()), 32'h1F);
        chk("wr_end_dq_oe",   32'(dq_oe),     32'h0);

        // Agent1 read back 0x00123
        set_agent(1, 1'b0, 18'h00123, 16'h0000, 2'b11);
        req = 3'b010;
        tick;
        chk("rd_ack",      32'(ack),       32'h2);
        chk("rd_strobes",  32'(strobes()), 32'h08);
        chk("rd_dq_oe",    32'(dq_oe),     32'h0);
        chk("rd_valid_early", 32'(rd_valid), 32'h0);
        req = 3'b000;
        tick;
        chk("rd_valid", 32'(rd_valid), 32'h2);
        chk("rd_data",  32'(rd_data),  32'hBEEF);
        chk("rd_end_strobes", 32'(strobes()), 32'h1F);
        tick;
        chk("rd_valid_pulse", 32'(rd_valid), 32'h0);
        chk("rd_data_hold",   32'(rd_data),  32'hBEEF);

        // Byte enables: write low byte only, then read with high byte strobe
        set_agent(0, 1'b1, 18'h00010, 16'h1234, 2'b01);
        req = 3'b001;
        tick;
        chk("be01_ack",     32'(ack),       32'h1);
        chk("be01_strobes", 32'(strobes()), 32'h05);
        req = 3'b000;
        tick;
        set_agent(0, 1'b0, 18'h00010, 16'h0000, 2'b10);
        req = 3'b001;
        tick;
        chk("be10_ack",     32'(ack),       32'h1);
        chk("be10_strobes", 32'(strobes()), 32'h0A);
        req = 3'b000;
        tick;
        chk("be10_rd_valid", 32'(rd_valid), 32'h1);
        chk("be10_rd_data",  32'(rd_data),  32'h0034);

        // be=00 read still runs a full cycle and returns rd_valid
        set_agent(1, 1'b0, 18'h00123, 16'h0000, 2'b00);
        req = 3'b010;
        tick;
        chk("be00_ack",     32'(ack),       32'h2);
        chk("be00_strobes", 32'(strobes()), 32'h0B);
        req = 3'b000;
        tick;
        chk("be00_rd_valid", 32'(rd_valid), 32'h2);

        // Idle: no request keeps the chip deselected
        for (int c = 0; c < 20; c++) begin
            tick;
            chk("idle_ce_n", 32'(ce_n), 32'h1);
        end

        // Round robin from reset: agent2 alone first, then all three continuously
        rst_il = 1'b0;
        tick;
        rst_il = 1'b1;
        for (int k = 0; k < 3; k++) set_agent(k, 1'b0, 18'(k), 16'h0000, 2'b11);
        req = 3'b100;
        tick;
        chk("rr_first_grant", 32'(ack), 32'h4);
        req = 3'b000;
        tick;
        chk("rr_first_rd_valid", 32'(rd_valid), 32'h4);
        req = 3'b111;
        for (int k = 0; k < 6; k++) begin
            tick;
            chk("rr_grant",    32'(ack), 32'(3'b001 << (k % 3)));
            tick;
            chk("rr_gap",      32'(ack), 32'h0);
            chk("rr_rd_valid", 32'(rd_valid), 32'(3'b001 << (k % 3)));
        end
        req = 3'b000;
        tick;

        // Random traffic: pad-direction and one-hot invariants
        for (int c = 0; c < 300; c++) begin
            for (int k = 0; k < 3; k++) begin
                if (!req[k] && $urandom_range(0, 2) == 0) begin
                    set_agent(k, 1'($urandom_range(0, 1)), 18'($urandom_range(0, 255)),
                              16'($urandom), 2'($urandom_range(0, 3)));
                    req[k] = 1'b1;
                end
            end
            tick;
            chk("no_drive_while_oe", 32'(dq_oe & ~oe_n), 32'h0);
            chk("ack_onehot",        32'($countones(ack) <= 1), 32'h1);
            chk("rd_valid_onehot",   32'($countones(rd_valid) <= 1), 32'h1);
            req = req & ~ack;
        end
        req = 3'b000;
        tick;
        tick;
        tick;

        // Asynchronous reset in the middle of a write
        set_agent(0, 1'b1, 18'h00055, 16'hA5A5, 2'b11);
        req = 3'b001;
        tick;
        chk("async_pre_ack",     32'(ack),       32'h1);
        chk("async_pre_strobes", 32'(strobes()), 32'h04);
        #2;
        rst_il = 1'b0;
        #1;
        chk("async_strobes", 32'(strobes()), 32'h1F);
        chk("async_dq_oe",   32'(dq_oe),     32'h0);
        chk("async_ack",     32'(ack),       32'h0);
        req = 3'b000;
        tick;
        rst_il = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick;
            chk("post_rst_ack",      32'(ack),       32'h0);
            chk("post_rst_rd_valid", 32'(rd_valid),  32'h0);
            chk("post_rst_strobes",  32'(strobes()), 32'h1F);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
